// File: rtl/btn_pkg.sv
// ============================================================================
// Module      : btn_pkg
// Description : Shared types and default timing constants for the button
//               press decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } press_state_t;

    localparam int c_clk_hz               = 100_000_000;
    localparam int c_tick_hz              = 100;
    localparam int c_tick_m_default       = c_clk_hz / c_tick_hz;
    localparam int c_long_ticks_default   = 100;
    localparam int c_dbl_ticks_default    = 30;
    localparam int c_repeat_ticks_default = 20;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module      : tick_gen
// Description : Free-running mod-M counter; max_tick is high for one clk
//               every M cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int M = 2
) (
    input  logic clk,
    input  logic reset,
    output logic max_tick
);

    localparam int              c_w    = (M > 1) ? $clog2(M) : 1;
    localparam logic [c_w-1:0]  c_last = c_w'(M - 1);

    logic [c_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_w'(1);
        end
    end

    assign max_tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/btn_press_decoder.sv
// ============================================================================
// Module      : btn_press_decoder
// Description : Classifies debounced button gestures into one-cycle short,
//               long and double-click pulses. Define AUTO_REPEAT_EN to get
//               rpt_p pulses while a long press is held.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_press_decoder
    import btn_pkg::*;
#(
    parameter int TICK_M       = c_tick_m_default,
    parameter int LONG_TICKS   = c_long_ticks_default,
    parameter int DBL_TICKS    = c_dbl_ticks_default,
    parameter int REPEAT_TICKS = c_repeat_ticks_default
) (
    input  logic clk,
    input  logic reset,
    input  logic db,
    output logic short_p,
    output logic long_p,
    output logic double_p,
    output logic rpt_p,
    output logic busy
);

    localparam int                  c_cnt_max  = max3(LONG_TICKS, DBL_TICKS, REPEAT_TICKS);
    localparam int                  c_cnt_w    = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0]  c_long_last = c_cnt_w'(LONG_TICKS - 1);
    localparam logic [c_cnt_w-1:0]  c_dbl_last  = c_cnt_w'(DBL_TICKS - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [c_cnt_w-1:0]  c_rpt_last  = c_cnt_w'(REPEAT_TICKS - 1);
`endif

    press_state_t       r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_db_q;
    logic               r_short_p;
    logic               r_long_p;
    logic               r_double_p;
    logic               w_tick;
    logic               w_rise;
    logic               w_fall;

    tick_gen #(
        .M (TICK_M)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .max_tick (w_tick)
    );

    assign w_rise = db & ~r_db_q;
    assign w_fall = ~db & r_db_q;

    function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] v);
        return (v == '1) ? v : v + c_cnt_w'(1);
    endfunction

`ifdef AUTO_REPEAT_EN
    logic r_rpt_p;
`endif

    // Edges are checked before ticks in every state, so an edge always wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_db_q     <= 1'b1;
            r_short_p  <= 1'b0;
            r_long_p   <= 1'b0;
            r_double_p <= 1'b0;
`ifdef AUTO_REPEAT_EN
            r_rpt_p    <= 1'b0;
`endif
        end else begin
            r_db_q     <= db;
            r_short_p  <= 1'b0;
            r_long_p   <= 1'b0;
            r_double_p <= 1'b0;
`ifdef AUTO_REPEAT_EN
            r_rpt_p    <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= PRESS1;
                        r_cnt   <= '0;
                    end
                end
                PRESS1: begin
                    if (w_fall) begin
                        r_state <= GAP;
                        r_cnt   <= '0;
                    end else if (w_tick) begin
                        if (r_cnt == c_long_last) begin
                            r_long_p <= 1'b1;
                            r_state  <= HOLD;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= sat_inc(r_cnt);
                        end
                    end
                end
                GAP: begin
                    if (w_rise) begin
                        r_double_p <= 1'b1;
                        r_state    <= PRESS2;
                        r_cnt      <= '0;
                    end else if (w_tick) begin
                        if (r_cnt == c_dbl_last) begin
                            r_short_p <= 1'b1;
                            r_state   <= IDLE;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= sat_inc(r_cnt);
                        end
                    end
                end
                PRESS2: begin
                    if (w_fall) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (w_fall) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
`ifdef AUTO_REPEAT_EN
                    else if (w_tick) begin
                        if (r_cnt == c_rpt_last) begin
                            r_rpt_p <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= sat_inc(r_cnt);
                        end
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign short_p  = r_short_p;
    assign long_p   = r_long_p;
    assign double_p = r_double_p;
    assign busy     = (r_state != IDLE);
`ifdef AUTO_REPEAT_EN
    assign rpt_p    = r_rpt_p;
`else
    assign rpt_p    = 1'b0;
`endif

endmodule

`default_nettype wire
